mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (legal 1..15).
REQ-002 Parameter: DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request strobe; MDop, A and B sampled with it.
REQ-006 MDop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 none.
REQ-007 A  input  32  operand rs.
REQ-008 B  input  32  operand rt.
REQ-009 busy  output  1  operation in progress; the pipeline stalls any MD instruction while high.
REQ-010 hi  output  32  architectural HI register, registered.
REQ-011 lo  output  32  architectural LO register, registered.

Function
REQ-012 States: IDLE, RUN; count register of 4 bits; result staging registers res_hi and res_lo.
REQ-013 IDLE, start=1, MDop in {1,2,3,4,7..10} -> RUN, busy=1 from next cycle, count loaded with MULT_CYCLES or DIV_CYCLES, operands latched, result computed into staging at acceptance.
REQ-014 RUN: count decrements every cycle; on the edge where count reaches 1 -> IDLE, hi/lo take staged result, busy falls the same edge.
REQ-015 busy high for exactly MULT_CYCLES (or DIV_CYCLES) cycles; hi/lo visible with the new value in the first cycle busy=0.
REQ-016 mult: {hi,lo} = signed A*B, 64 bits; multu: unsigned 64-bit product.
REQ-017 div: lo = signed A/B truncated toward zero, hi = remainder with sign of A; divu unsigned.
REQ-018 Division with B=0: operation still runs DIV_CYCLES, hi and lo unchanged at completion.
REQ-019 div with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no exception).
REQ-020 madd/maddu: {hi,lo} = {hi,lo} + product (signed/unsigned), modulo 2^64; msub/msubu subtract, modulo 2^64; hi/lo read at acceptance.
REQ-021 mthi: hi=A on the next edge; mtlo: lo=A on the next edge; no busy, lo/hi other half unchanged.
REQ-022 start while busy=1: ignored completely, no state change (caller stalls; not an error).
REQ-023 start in IDLE with MDop 0 or 11-15: ignored.
REQ-024 start coincident with completion edge is ignored (busy still 1 that cycle).
REQ-025 Outputs registered only; no combinational path from inputs to hi, lo or busy.

Reset
REQ-026 reset=1 at a clock edge: state IDLE, count 0, busy 0, hi 0, lo 0, staging 0.
REQ-027 reset mid-operation aborts it; no partial result ever reaches hi/lo.
REQ-028 reset has priority over start and over completion on the same edge.

Configuration
REQ-029 Macro MDU_MSUB_EN: defined -> MDop 7-10 behave per REQ-020.
REQ-030 MDU_MSUB_EN undefined -> MDop 7-10 treated as none (REQ-023), no accumulate logic synthesised.

Verification
REQ-031 A=0xFFFFFFFE, B=3, mult -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-032 A=0xFFFFFFF9 (-7), B=2, div -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then A=5, B=0, div -> hi/lo unchanged after 10 cycles.
REQ-033 mthi 0x1, mtlo 0x0, msub A=1 B=1 (MDU_MSUB_EN) -> hi=0x0, lo=0xFFFFFFFF; madd same operands -> hi=0x1, lo=0x0.
REQ-034 mult started, second start (div) at busy cycle 2 and at completion edge -> both ignored, only mult result appears, busy falls after exactly 5 cycles.
REQ-035 div started, reset asserted at busy cycle 4 -> next cycle busy=0, hi=0, lo=0; no later update.
REQ-036 MDU_MSUB_EN undefined, start with MDop=9 -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: fixed-latency mult/div with staged result.
// Optional accumulate ops (madd/maddu/msub/msubu) enabled by MDU_MSUB_EN.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MSUB_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MCNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DCNT = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic        is_mul;
  logic        is_div;
  logic        is_sgn;
  logic        is_mthi;
  logic        is_mtlo;
`ifdef MDU_MSUB_EN
  logic        is_acc;
  logic        is_sub;
`endif

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uquo;
  logic [31:0] urem;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] hilo;
  logic [63:0] nxt;
  logic        accept;

  // operation decode
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
`ifdef MDU_MSUB_EN
    is_acc  = 1'b0;
    is_sub  = 1'b0;
`endif
    case (MDop)
      OP_MULT: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV: begin
        is_div = 1'b1;
        is_sgn = 1'b1;
      end
      OP_DIVU: is_div = 1'b1;
      OP_MTHI: is_mthi = 1'b1;
      OP_MTLO: is_mtlo = 1'b1;
`ifdef MDU_MSUB_EN
      OP_MADD: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
        is_acc = 1'b1;
      end
      OP_MADDU: begin
        is_mul = 1'b1;
        is_acc = 1'b1;
      end
      OP_MSUB: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
        is_acc = 1'b1;
        is_sub = 1'b1;
      end
      OP_MSUBU: begin
        is_mul = 1'b1;
        is_acc = 1'b1;
        is_sub = 1'b1;
      end
`endif
      default: begin
        is_mul = 1'b0;
      end
    endcase
  end

  // one 64x64 multiplier serves signed and unsigned: low 64 bits agree
  always_comb begin
    ext_a = {{32{is_sgn & A[31]}}, A};
    ext_b = {{32{is_sgn & B[31]}}, B};
    prod  = ext_a * ext_b;
  end

  // one unsigned divider on magnitudes; signs restored afterwards.
  // 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
  always_comb begin
    neg_a = is_sgn & A[31];
    neg_b = is_sgn & B[31];
    mag_a = neg_a ? (32'd0 - A) : A;
    mag_b = neg_b ? (32'd0 - B) : B;
    if (mag_b == 32'd0) begin
      uquo = 32'd0;
      urem = 32'd0;
    end else begin
      uquo = mag_a / mag_b;
      urem = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? (32'd0 - uquo) : uquo;
    rem = neg_a ? (32'd0 - urem) : urem;
  end

  // result to stage at acceptance; divide by zero keeps HI/LO
  always_comb begin
    hilo = {hi, lo};
    nxt  = hilo;
    if (is_div) begin
      if (B != 32'd0) begin
        nxt = {rem, quo};
      end
    end else if (is_mul) begin
`ifdef MDU_MSUB_EN
      if (is_acc) begin
        nxt = is_sub ? (hilo - prod) : (hilo + prod);
      end else begin
        nxt = prod;
      end
`else
      nxt = prod;
`endif
    end
  end

  assign accept = start & (state == IDLE) & (is_mul | is_div);

  // control FSM, staging and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            busy   <= 1'b1;
            count  <= is_div ? DCNT : MCNT;
            res_hi <= nxt[63:32];
            res_lo <= nxt[31:0];
          end else if (start & is_mthi) begin
            hi <= A;
          end else if (start & is_mtlo) begin
            lo <= A;
          end
        end
        RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, queued expectations.
// Checks results at busy fall (with busy length) or on explicit observe.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  MDop = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt = 0;
  logic pbusy = 1'b0;
  logic obs = 1'b0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .MDop(MDop),
    .A(A),
    .B(B),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_pop(input int got_cyc);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output hi=%h lo=%h busy_cycles=%0d required=none",
               hi, lo, got_cyc);
    end else begin
      e = q.pop_front();
      checks += 3;
      if (hi !== e.h) begin
        errors++;
        $display("FAIL hi got=%h required=%h", hi, e.h);
      end
      if (lo !== e.l) begin
        errors++;
        $display("FAIL lo got=%h required=%h", lo, e.l);
      end
      if (e.cyc >= 0) begin
        if (got_cyc != e.cyc) begin
          errors++;
          $display("FAIL busy_len got=%0d required=%0d", got_cyc, e.cyc);
        end
      end else if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle got=%b required=0", busy);
      end
    end
  endtask

  // monitor: sample on falling edge, away from the active edge
  always @(negedge clk) begin
    if (busy === 1'b1) bcnt++;
    if (pbusy && busy === 1'b0) begin
      check_pop(bcnt);
      bcnt = 0;
    end else if (obs) begin
      check_pop(-1);
    end
    pbusy = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input logic [31:0] h, input logic [31:0] l);
    q.push_back('{h, l, -1});
    obs = 1'b1;
    tick();
    obs = 1'b0;
  endtask

  task automatic poke(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    MDop  = op;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    MDop  = 4'd0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h,
                        input logic [31:0] l, input int cyc);
    int n;
    q.push_back('{h, l, cyc});
    poke(op, a, b);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout busy still=%b after=%0d required=0", busy, n);
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    expect_obs(32'h0, 32'h0);

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    run_op(4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd3, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd4, 32'd100, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    run_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op(4'd3, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 10);
    run_op(4'd3, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 10);
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 10);

    poke(4'd0, 32'd9, 32'd9);
    expect_obs(32'd1, 32'h7FFFFFFC);
    poke(4'd12, 32'd9, 32'd9);
    poke(4'd15, 32'd9, 32'd9);
    repeat (12) tick();
    expect_obs(32'd1, 32'h7FFFFFFC);

    poke(4'd5, 32'h1, 32'h0);
    expect_obs(32'h1, 32'h7FFFFFFC);
    poke(4'd6, 32'h0, 32'h0);
    expect_obs(32'h1, 32'h0);

`ifdef MDU_MSUB_EN
    run_op(4'd9, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 5);
    run_op(4'd7, 32'd1, 32'd1, 32'h1, 32'h0, 5);
    run_op(4'd10, 32'd2, 32'd3, 32'h0, 32'hFFFFFFFA, 5);
    run_op(4'd8, 32'hFFFFFFFF, 32'd2, 32'h2, 32'hFFFFFFF8, 5);
    run_op(4'd7, 32'hFFFFFFFF, 32'd1, 32'h2, 32'hFFFFFFF7, 5);
`else
    poke(4'd9, 32'd1, 32'd1);
    expect_obs(32'h1, 32'h0);
    poke(4'd7, 32'd1, 32'd1);
    repeat (12) tick();
    expect_obs(32'h1, 32'h0);
`endif

    poke(4'd5, 32'h12345678, 32'h0);
    poke(4'd6, 32'h9ABCDEF0, 32'h0);
    expect_obs(32'h12345678, 32'h9ABCDEF0);

    // second start during busy and on the completion edge
    q.push_back('{32'h0, 32'd42, 5});
    poke(4'd1, 32'd7, 32'd6);
    tick();
    MDop  = 4'd3;
    A     = 32'd5;
    B     = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    MDop  = 4'd0;
    repeat (15) tick();
    expect_obs(32'h0, 32'd42);

    // reset during a divide
    q.push_back('{32'h0, 32'h0, 4});
    poke(4'd3, 32'd100, 32'd7);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    expect_obs(32'h0, 32'h0);

    repeat (2) tick();
    checks++;
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL pending got=%0d entries required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
